// File: rtl/spi_reg_decoder.sv
// SPI byte-stream register decoder: command byte selects write/discard, data bytes fill an 8-bit register file.
// Optional build macro SPI_REG_SHADOW_EN stages writes in a shadow file that is committed atomically at frame end.
module spi_reg_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  byte_clock_n_i,
  input  logic                  spi_csn_i,
  output logic [8*NUM_REGS-1:0] cfg_regs_o,
  output logic                  wr_stb_o,
  output logic [6:0]            wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  frame_active_o,
  output logic                  addr_err_o,
  output logic                  commit_o
);

  localparam logic [7:0] NREGS_W = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, DISCARD} state_t;

  state_t                   state_q, state_d;
  logic [5:0]               cs_q;
  logic [5:0]               cs_live_q;
  logic [6:0]               addr_q, addr_d;
  logic                     strobe;
  logic                     frame_start;
  logic                     frame_end;
  logic                     addr_in_range;
  logic                     wr_en;
  logic                     err_set;
  logic                     wr_stb_p1;
  logic [6:0]               wr_addr_p1;
  logic [7:0]               wr_data_p1;
  logic                     commit_p1;
  logic                     active_q;
  logic                     err_q;
  logic [NUM_REGS-1:0][7:0] cfg_q;

  // Stage 0: chip-select synchroniser. cs_live_q marks which chain bits hold
  // real samples, so the reset-preset ones never count as a CS-high period.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cs_q      <= '1;
      cs_live_q <= '0;
    end else begin
      cs_q      <= {cs_q[4:0], spi_csn_i};
      cs_live_q <= {cs_live_q[4:0], 1'b1};
    end
  end

  assign strobe        = ~byte_clock_n_i;
  assign frame_start   = (state_q == IDLE) & cs_live_q[5] & cs_q[5] & ~cs_q[4];
  assign frame_end     = (state_q != IDLE) & ~cs_q[5] & cs_q[4];
  assign addr_in_range = {1'b0, addr_q} < NREGS_W;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = CMD;
      end
      CMD: begin
        if (strobe) begin
          if (rx_data_i[7]) begin
            state_d = WRITE;
            addr_d  = rx_data_i[6:0];
          end else begin
            state_d = DISCARD;
          end
        end
      end
      WRITE: begin
        if (strobe) begin
          wr_en   = addr_in_range;
          err_set = ~addr_in_range;
          if (addr_q != 7'h7F) addr_d = addr_q + 7'd1;
        end
      end
      default: ;
    endcase
    // A byte landing in the frame-end cycle is still decoded above.
    if (frame_end) state_d = IDLE;
  end

  // Stage 1: FSM state, write/commit pulses and frame status
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_stb_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      commit_p1  <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_stb_p1 <= wr_en;
      commit_p1 <= frame_end;
      if (wr_en) begin
        wr_addr_p1 <= addr_q;
        wr_data_p1 <= rx_data_i;
      end
      if (frame_start)    active_q <= 1'b1;
      else if (frame_end) active_q <= 1'b0;
      if (frame_start)    err_q <= 1'b0;
      else if (err_set)   err_q <= 1'b1;
    end
  end

`ifdef SPI_REG_SHADOW_EN
  logic [NUM_REGS-1:0][7:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en && addr_q == 7'(k)) shadow_d[k] = rx_data_i;
    end
  end

  // Stage 1: shadow file tracks the live registers at frame start, commits at frame end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      cfg_q    <= '0;
    end else begin
      if (frame_start) shadow_q <= cfg_q;
      else             shadow_q <= shadow_d;
      if (frame_end)   cfg_q    <= shadow_d;
    end
  end
`else
  // Stage 1: direct register file write
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cfg_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_en && addr_q == 7'(k)) cfg_q[k] <= rx_data_i;
      end
    end
  end
`endif

  assign cfg_regs_o     = cfg_q;
  assign wr_stb_o       = wr_stb_p1;
  assign wr_addr_o      = wr_addr_p1;
  assign wr_data_o      = wr_data_p1;
  assign commit_o       = commit_p1;
  assign frame_active_o = active_q;
  assign addr_err_o     = err_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench for spi_reg_decoder: directed frames plus random frames against a byte-level reference model.
// Builds with or without SPI_REG_SHADOW_EN; the model follows the same macro.
module tb_spi_reg_decoder;
  localparam int NUM_REGS = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_n_i = 1'b0;
  logic [7:0]            rx_data_i = 8'h00;
  logic                  byte_clock_n_i = 1'b1;
  logic                  spi_csn_i = 1'b1;
  logic [8*NUM_REGS-1:0] cfg_regs_o;
  logic                  wr_stb_o;
  logic [6:0]            wr_addr_o;
  logic [7:0]            wr_data_o;
  logic                  frame_active_o;
  logic                  addr_err_o;
  logic                  commit_o;

  spi_reg_decoder #(.NUM_REGS(NUM_REGS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_data_i(rx_data_i),
    .byte_clock_n_i(byte_clock_n_i), .spi_csn_i(spi_csn_i),
    .cfg_regs_o(cfg_regs_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .frame_active_o(frame_active_o),
    .addr_err_o(addr_err_o), .commit_o(commit_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int commit_cnt = 0;
  int exp_wr_total = 0;

  // Reference model: committed registers, in-frame working copy, frame progress
  logic [7:0] exp_regs [NUM_REGS];
  logic [7:0] pend     [NUM_REGS];
  logic [7:0] commit_regs [NUM_REGS];
  bit         in_frame = 1'b0;
  int         idx = 0;
  logic [7:0] cmd = 8'h00;
  bit         exp_err = 1'b0;
  logic [7:0] fq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] reg_at(input int k);
    return cfg_regs_o[8*k +: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) begin
    #1;
    if (wr_stb_o === 1'b1) wr_cnt++;
    if (commit_o === 1'b1) begin
      commit_cnt++;
      for (int k = 0; k < NUM_REGS; k++)
        check($sformatf("commit_reg%0d", k), 32'(reg_at(k)), 32'(commit_regs[k]));
    end
  end

  // Decide what one received byte should do: the n-th data byte after a write
  // command targets min(cmd_addr + n - 1, 127).
  task automatic model_byte(input logic [7:0] b, output bit exp_wr, output int a);
    exp_wr = 1'b0;
    a = 0;
    if (in_frame) begin
      if (idx == 0) begin
        cmd = b;
      end else if (cmd[7]) begin
        a = int'(cmd[6:0]) + idx - 1;
        if (a > 127) a = 127;
        if (a < NUM_REGS) begin
          exp_wr = 1'b1;
          pend[a] = b;
`ifndef SPI_REG_SHADOW_EN
          exp_regs[a] = b;
`endif
        end else begin
          exp_err = 1'b1;
        end
      end
      idx++;
    end
    if (exp_wr) exp_wr_total++;
  endtask

  task automatic check_write(input bit exp_wr, input int a, input logic [7:0] b);
    check("wr_stb", 32'(wr_stb_o), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 32'(wr_addr_o), 32'(a));
      check("wr_data", 32'(wr_data_o), 32'(b));
      check($sformatf("reg%0d_after_wr", a), 32'(reg_at(a)), 32'(exp_regs[a]));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit exp_wr;
    int a;
    model_byte(b, exp_wr, a);
    rx_data_i = b;
    byte_clock_n_i = 1'b0;
    tick(1);
    byte_clock_n_i = 1'b1;
    check_write(exp_wr, a, b);
    tick($urandom_range(1, 3));
  endtask

  task automatic start_frame();
    check("err_hold_idle", 32'(addr_err_o), 32'(exp_err));
    spi_csn_i = 1'b0;
    tick(8);
    in_frame = 1'b1;
    idx = 0;
    exp_err = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) pend[k] = exp_regs[k];
    check("active_start", 32'(frame_active_o), 32'h1);
    check("err_clr_start", 32'(addr_err_o), 32'h0);
  endtask

  // Close the frame; with merge set, the last byte is strobed in the exact
  // cycle the synchronised CS rising edge is acted on.
  task automatic end_frame(input bit merge, input logic [7:0] lb);
    bit exp_wr;
    int a, c0;
    exp_wr = 1'b0;
    a = 0;
    if (merge) model_byte(lb, exp_wr, a);
    for (int k = 0; k < NUM_REGS; k++) commit_regs[k] = pend[k];
    c0 = commit_cnt;
    spi_csn_i = 1'b1;
    if (merge) begin
      tick(5);
      rx_data_i = lb;
      byte_clock_n_i = 1'b0;
      tick(1);
      byte_clock_n_i = 1'b1;
      for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = pend[k];
      check_write(exp_wr, a, lb);
      check("commit_merge", 32'(commit_o), 32'h1);
      tick(3);
    end else begin
      tick(9);
    end
    in_frame = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = pend[k];
    check("commit_once", 32'(commit_cnt - c0), 32'h1);
    check("active_end", 32'(frame_active_o), 32'h0);
    check("err_end", 32'(addr_err_o), 32'(exp_err));
    for (int k = 0; k < NUM_REGS; k++)
      check($sformatf("reg%0d_end", k), 32'(reg_at(k)), 32'(exp_regs[k]));
  endtask

  task automatic run_frame(input bit merge);
    start_frame();
    for (int i = 0; i < fq.size() - (merge ? 1 : 0); i++) send_byte(fq[i]);
    end_frame(merge, merge ? fq[fq.size()-1] : 8'h00);
    tick($urandom_range(2, 5));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_stb"}, 32'(wr_stb_o), 32'h0);
    check({tag, "_wr_addr"}, 32'(wr_addr_o), 32'h0);
    check({tag, "_wr_data"}, 32'(wr_data_o), 32'h0);
    check({tag, "_commit"}, 32'(commit_o), 32'h0);
    check({tag, "_err"}, 32'(addr_err_o), 32'h0);
    check({tag, "_active"}, 32'(frame_active_o), 32'h0);
    check({tag, "_cfg"}, 32'(cfg_regs_o != '0), 32'h0);
  endtask

  initial begin
    int c0, sel, n;
    for (int k = 0; k < NUM_REGS; k++) begin
      exp_regs[k] = 8'h00;
      pend[k] = 8'h00;
      commit_regs[k] = 8'h00;
    end
    tick(3);
    check_reset_state("rst0");
    rst_n_i = 1'b1;
    tick(10);

    fq = '{8'h83, 8'h11, 8'h22};          run_frame(1'b0);
    fq = '{8'h8E, 8'hA1, 8'hA2, 8'hA3};   run_frame(1'b0);
    fq = '{8'h05, 8'h55, 8'h66};          run_frame(1'b0);
    fq = '{8'hFF, 8'h01, 8'h02, 8'h03};   run_frame(1'b0);
    fq = '{8'h80, 8'h12};                 run_frame(1'b0);
    fq = '{8'h84, 8'h5A};                 run_frame(1'b1);

    // Reset in the middle of a write frame, then bytes while CS stays low
    c0 = commit_cnt;
    start_frame();
    send_byte(8'h81);
    send_byte(8'h33);
    rst_n_i = 1'b0;
    tick(2);
    for (int k = 0; k < NUM_REGS; k++) begin
      exp_regs[k] = 8'h00;
      pend[k] = 8'h00;
    end
    in_frame = 1'b0;
    exp_err = 1'b0;
    check_reset_state("rst_mid");
    rst_n_i = 1'b1;
    tick(10);
    send_byte(8'h81);
    send_byte(8'h44);
    check("active_after_rst", 32'(frame_active_o), 32'h0);
    spi_csn_i = 1'b1;
    tick(10);
    check("no_commit_rst", 32'(commit_cnt - c0), 32'h0);
    check("reg1_after_rst", 32'(reg_at(1)), 32'h0);
    fq = '{8'h81, 8'h77};                 run_frame(1'b0);

    for (int f = 0; f < 25; f++) begin
      sel = $urandom_range(0, 3);
      fq.delete();
      case (sel)
        0:       fq.push_back({1'b0, 7'($urandom_range(0, 127))});
        1:       fq.push_back(8'h80 | 8'($urandom_range(NUM_REGS - 3, NUM_REGS + 1)));
        2:       fq.push_back(8'h80 | 8'($urandom_range(0, NUM_REGS - 1)));
        default: fq.push_back(8'h80 | 8'($urandom_range(123, 127)));
      endcase
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) fq.push_back(8'($urandom_range(0, 255)));
      run_frame($urandom_range(0, 2) == 0);
    end

    check("wr_total", 32'(wr_cnt), 32'(exp_wr_total));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_decoder.md
SPI_REG_DECODER -- requirements
Module: spi_reg_decoder

Interface
REQ-001 Parameter NUM_REGS, default 16, number of 8-bit configuration registers; legal range 2..128.
REQ-002 clk_i  input  1  system clock; single clock domain, all logic on rising edge.
REQ-003 rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 rx_data_i  input  8  received SPI byte; valid in the cycle byte_clock_n_i is low.
REQ-005 byte_clock_n_i  input  1  active-low byte strobe, low exactly one clk_i cycle per received byte.
REQ-006 spi_csn_i  input  1  raw SPI chip select, asynchronous to clk_i, active low.
REQ-007 cfg_regs_o  output  8*NUM_REGS  register file, register k on bits [8k+7:8k].
REQ-008 wr_stb_o  output  1  one-cycle pulse per accepted register write.
REQ-009 wr_addr_o  output  7  address of the accepted write; valid with wr_stb_o.
REQ-010 wr_data_o  output  8  data of the accepted write; valid with wr_stb_o.
REQ-011 frame_active_o  output  1  high while a frame is open (synchronised CS low).
REQ-012 addr_err_o  output  1  sticky: a write in the current or last frame targeted address >= NUM_REGS.
REQ-013 commit_o  output  1  one-cycle pulse at frame end.

Function
REQ-014 spi_csn_i SHALL pass through a 6-flop chain; frame start/end are its falling/rising edges at the chain output, so that the last byte strobe of a frame always precedes frame end.
REQ-015 States: IDLE, CMD, WRITE, DISCARD; reset state IDLE.
REQ-016 IDLE -> CMD on frame start; addr_err_o cleared in the same cycle; frame_active_o high from the next cycle.
REQ-017 CMD, strobe: bit7=1 -> WRITE, address counter loaded with bits[6:0]; bit7=0 -> DISCARD; no write issued for the command byte.
REQ-018 WRITE, strobe: if address < NUM_REGS, write rx_data_i there, wr_stb_o/wr_addr_o/wr_data_o asserted next cycle; otherwise write dropped, addr_err_o set, no wr_stb_o.
REQ-019 After each data byte the 7-bit address counter increments, saturating at 127 (no wrap to 0).
REQ-020 DISCARD ignores all strobes until frame end.
REQ-021 Any state -> IDLE on frame end; commit_o pulses the following cycle; frame_active_o low from that cycle.
REQ-022 Strobes in IDLE ignored.
REQ-023 Strobe and frame end in the same cycle: byte processed first, then IDLE; commit_o still pulses once.
REQ-024 Strobe-to-wr_stb_o latency exactly 1 cycle; at most one write per strobe.

Reset
REQ-025 While rst_n_i is low at a clock edge: state IDLE, cfg_regs_o all zero, shadow zero, address 0, wr_stb_o/commit_o/addr_err_o/frame_active_o low, wr_addr_o/wr_data_o zero, CS chain all ones.
REQ-026 Reset mid-frame SHALL abandon the frame; after release a new frame start is required before bytes are accepted.

Configuration
REQ-027 Macro SPI_REG_SHADOW_EN defined: writes go to a shadow file; cfg_regs_o loaded from the shadow atomically in the commit_o cycle; shadow starts each frame as a copy of cfg_regs_o.
REQ-028 SPI_REG_SHADOW_EN undefined: no shadow storage; cfg_regs_o updated in the wr_stb_o cycle; commit_o still pulses.

Verification
REQ-029 Frame 0x83,0x11,0x22 -> wr_stb_o twice, (3,0x11) then (4,0x22); cfg reg3=0x11, reg4=0x22; commit_o once; addr_err_o=0.
REQ-030 NUM_REGS=16, frame 0x8E,0xA1,0xA2,0xA3 -> regs 14,15 = 0xA1,0xA2; third byte dropped; addr_err_o=1 until next frame start.
REQ-031 Frame 0x05,0x55,0x66 -> no wr_stb_o, all regs unchanged, commit_o once.
REQ-032 Frame 0xFF then 3 data bytes -> address saturates at 127, no writes, addr_err_o=1, no wrap into reg 0.
REQ-033 SPI_REG_SHADOW_EN: frame 0x80,0x12 -> cfg reg0 stays 0 until commit_o cycle, then 0x12; without macro reg0=0x12 one cycle after strobe.
REQ-034 Reset asserted after 0x81,0x33 mid-frame -> all outputs zero; bytes after release ignored until CS toggles high then low.
